aes256_ctr_block_encrypt: RTL and testbench

- Single-block AES-256 counter-mode encryptor.
- After reset release it encrypts one counter block (COUNTER_INIT) under key_i using an iterative, one-round-per-clock AES-256 core with on-the-fly key expansion.
- It XORs the resulting keystream with plaintext and then holds both results.
- Sits between the key/data source and the downstream consumer of ciphertext; one block per reset.

---
 rtl/aes256_ctr_block_encrypt.sv | 182 ++++++++++++++++++
 tb/tb_aes256_ctr_block_encrypt.sv | 135 +++++++++++++
 2 files changed

// File: rtl/aes256_ctr_block_encrypt.sv
// Single-block AES-256 CTR encryptor: one round per clock,
// round keys expanded on the fly from an 8-word window.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gmul(
    input logic [7:0] x,
    input logic [7:0] y
  );
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0.
  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign s = sbox_f(a);

endmodule

module aes256_ctr_block_encrypt #(
  parameter logic [127:0] COUNTER_INIT = 128'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] plaintext,
  input  logic [255:0] key_i,
  output logic [127:0] cipher_counter_o,
  output logic [127:0] ciphertext,
  output logic         done_o
);

  typedef enum logic [1:0] {LOAD, ROUND, DONE} fsm_t;

  fsm_t         fsm_q;
  fsm_t         fsm_d;
  logic [127:0] state_q;
  logic [255:0] key_q;
  logic [3:0]   round_q;
  logic [7:0]   rcon_q;

  logic [127:0] sb;
  logic [127:0] sr;
  logic [127:0] mc;
  logic [127:0] rk;
  logic [127:0] ks;
  logic         last;
  logic         odd;
  logic [31:0]  kin;
  logic [31:0]  ksub;
  logic [31:0]  t;
  logic [31:0]  nw0;
  logic [31:0]  nw1;
  logic [31:0]  nw2;
  logic [31:0]  nw3;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_dsbox
    aes_sbox u_sbox (
      .a (state_q[8*i +: 8]),
      .s (sb[8*i +: 8])
    );
  end

  for (genvar i = 0; i < 4; i++) begin : g_ksbox
    aes_sbox u_sbox (
      .a (kin[8*i +: 8]),
      .s (ksub[8*i +: 8])
    );
  end

  // Column c occupies bits [32c+31:32c], row r its byte r.
  always_comb begin
    sr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[32*c + 8*r +: 8] = sb[32*((c + r) % 4) + 8*r +: 8];
      end
    end
  end

  always_comb begin
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      logic [7:0] a0, a1, a2, a3;
      a0 = sr[32*c      +: 8];
      a1 = sr[32*c + 8  +: 8];
      a2 = sr[32*c + 16 +: 8];
      a3 = sr[32*c + 24 +: 8];
      mc[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  end

  // Odd rounds produce the RotWord/Rcon words of the schedule.
  assign rk   = key_q[255:128];
  assign last = (round_q == 4'd14);
  assign odd  = round_q[0];
  assign kin  = odd ? {key_q[231:224], key_q[255:232]}
                    : key_q[255:224];
  assign t    = ksub ^ {24'h0, (odd ? rcon_q : 8'h00)};
  assign nw0  = key_q[31:0]  ^ t;
  assign nw1  = key_q[63:32] ^ nw0;
  assign nw2  = key_q[95:64] ^ nw1;
  assign nw3  = key_q[127:96] ^ nw2;
  assign ks   = sr ^ rk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= LOAD;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      LOAD:    fsm_d = ROUND;
      ROUND:   if (last) fsm_d = DONE;
      DONE:    fsm_d = DONE;
      default: fsm_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= '0;
      key_q            <= '0;
      round_q          <= '0;
      rcon_q           <= '0;
      cipher_counter_o <= '0;
      ciphertext       <= '0;
      done_o           <= 1'b0;
    end else begin
      unique case (fsm_q)
        LOAD: begin
          state_q <= COUNTER_INIT ^ key_i[127:0];
          key_q   <= key_i;
          rcon_q  <= 8'h01;
          round_q <= 4'd1;
        end
        ROUND: begin
          key_q <= {nw3, nw2, nw1, nw0, key_q[255:128]};
          if (odd) rcon_q <= xtime(rcon_q);
          if (last) begin
            cipher_counter_o <= ks;
            ciphertext       <= ks ^ plaintext;
            done_o           <= 1'b1;
          end else begin
            state_q <= mc ^ rk;
            round_q <= round_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes256_ctr_block_encrypt.sv
// Directed bench: FIPS-197 C.3 vectors, latency, async reset,
// CTR round trip and an all-zero key/counter instance.
module tb_aes256_ctr_block_encrypt;

  localparam logic [127:0] CTR  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [255:0] KEY  =
    256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] KS   = 128'h8960494b9049fceabf456751cab7a28e;
  localparam logic [127:0] CT2  = 128'h768e94872be36562c8233215f995b38e;
  localparam logic [127:0] ZREF = 128'h8720849214a248ad898940a278c095dc;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] plaintext = '0;
  logic [255:0] key_i = KEY;
  logic [127:0] cipher_counter_o;
  logic [127:0] ciphertext;
  logic         done_o;
  logic [127:0] z_pt = '0;
  logic [255:0] z_key = '0;
  logic [127:0] z_ctr;
  logic [127:0] z_ct;
  logic         z_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes256_ctr_block_encrypt #(.COUNTER_INIT(CTR)) u_dut (
    .clk              (clk),
    .rst              (rst),
    .plaintext        (plaintext),
    .key_i            (key_i),
    .cipher_counter_o (cipher_counter_o),
    .ciphertext       (ciphertext),
    .done_o           (done_o)
  );

  aes256_ctr_block_encrypt u_zero (
    .clk              (clk),
    .rst              (rst),
    .plaintext        (z_pt),
    .key_i            (z_key),
    .cipher_counter_o (z_ctr),
    .ciphertext       (z_ct),
    .done_o           (z_done)
  );

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic run15();
    repeat (14) edge1();
    check("done_e14", done_o, 0);
    edge1();
    check("done_e15", done_o, 1);
  endtask

  initial begin
    repeat (10) edge1();
    check("rst_ctr", cipher_counter_o, 0);
    check("rst_ct", ciphertext, 0);
    check("rst_done", done_o, 0);

    @(negedge clk) rst = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      edge1();
      check($sformatf("lat_e%0d", e), done_o, 0);
    end
    edge1();
    check("c3_done", done_o, 1);
    check("c3_ctr", cipher_counter_o, KS);
    check("c3_ct", ciphertext, KS);
    check("zero_done", z_done, 1);
    check("zero_ctr", z_ctr, ZREF);
    check("zero_ct", z_ct, ZREF);

    plaintext = CTR;
    pulse_rst();
    run15();
    check("pt_ct", ciphertext, CT2);
    check("pt_ctr", cipher_counter_o, KS);
    #6000;
    check("hold_ct", ciphertext, CT2);
    check("hold_ctr", cipher_counter_o, KS);
    check("hold_done", done_o, 1);

    #2 rst = 1'b1;
    #1;
    check("async_ctr", cipher_counter_o, 0);
    check("async_ct", ciphertext, 0);
    check("async_done", done_o, 0);

    @(negedge clk) rst = 1'b0;
    repeat (7) edge1();
    rst = 1'b1;
    #1;
    check("mid_ct", ciphertext, 0);
    check("mid_done", done_o, 0);
    @(negedge clk) rst = 1'b0;
    run15();
    check("mid_ct_ok", ciphertext, CT2);

    plaintext = CT2;
    pulse_rst();
    run15();
    check("rt_ct", ciphertext, CTR);
    check("rt_ctr", cipher_counter_o, KS);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
